dest_demux_fifo: RTL
====================

Name: dest_demux_fifo

Overview:
- Downstream stage of the VC0/VC1 destination mux.
- Consumes the mux's registered word and valid, and routes each valid word by its destination bit into one of two destination FIFOs (D0, D1).
- Each FIFO has its own pop interface and status flags. These feed the external consumers and the backpressure (almost-full) logic upstream of the VC FIFOs.

Parameters:
- BITNUMBER, 6, word width (same word as the mux output).
- DEST_BIT, 4, bit index of data_in that selects the destination: 0 routes to D0, 1 routes to D1.
- FIFO_DEPTH, 4, entries per destination FIFO. Must be a power of 2, at least 2.
- AF_THRESH, 3, almost_full asserts when occupancy >= AF_THRESH. Range 1..FIFO_DEPTH.
- AE_THRESH, 1, almost_empty asserts when occupancy <= AE_THRESH. Range 0..FIFO_DEPTH-1.

Ports:
- clk  in  1  single clock, all state on the rising edge.
- reset  in  1  synchronous, active-high.
- data_in  in  BITNUMBER  word from the destination mux (data_out_dest).
- valid_in  in  1  data_in is valid this cycle (valid_out_dest).
- pop_D0  in  1  read request, FIFO D0.
- pop_D1  in  1  read request, FIFO D1.
- data_out_D0  out  BITNUMBER  registered read data, D0.
- data_out_D1  out  BITNUMBER  registered read data, D1.
- valid_out_D0  out  1  data_out_D0 valid.
- valid_out_D1  out  1  data_out_D1 valid.
- empty_D0, empty_D1  out  1 each  occupancy == 0.
- full_D0, full_D1  out  1 each  occupancy == FIFO_DEPTH.
- almost_full_D0, almost_full_D1  out  1 each  occupancy >= AF_THRESH.
- almost_empty_D0, almost_empty_D1  out  1 each  occupancy <= AE_THRESH.
- overflow_err  out  1  sticky: a word was dropped.
- idle  out  1  both FIFOs empty and valid_in == 0.

Behaviour:
- Reset:
  - Applies while reset == 1 at a rising edge.
  - Clears all pointers and occupancy counts.
  - Drives data_out_*, valid_out_* and overflow_err to 0.
  - Takes priority over push and pop in the same cycle. Storage contents are not cleared (not observable).
  - Flags after reset: empty=1, full=0, almost_full=0, almost_empty=1.
  - Reset mid-operation discards all buffered words; nothing is output for them.
- Routing: when valid_in == 1, the word goes to D0 if data_in[DEST_BIT] == 0, otherwise to D1. The word is stored unmodified (destination bit kept). Exactly one FIFO is written per valid word. valid_in == 0 writes nothing.
- Push:
  - The written word is visible at the head at the next edge.
  - Occupancy increments at the same edge. The write pointer wraps modulo FIFO_DEPTH.
- Pop:
  - A pop with the FIFO not empty (based on registered occupancy) registers the head word into data_out_Dx with valid_out_Dx = 1 at the next edge.
  - Read latency is 1 cycle. The read pointer wraps modulo FIFO_DEPTH.
- Pop on empty: ignored. At the next edge valid_out_Dx = 0, data_out_Dx = 0, and pointers are unchanged.
- No pop: at the next edge valid_out_Dx = 0 and data_out_Dx = 0. data_out is not held.
- Push and pop on the same FIFO in the same cycle:
  - Not empty: both are performed and occupancy is unchanged. This includes the full case, where the push is accepted because a slot is freed that cycle.
  - Empty: the push is performed and the pop is ignored. There is no bypass.
- Overflow: a push to a full FIFO with no simultaneous pop drops the word and sets overflow_err = 1. overflow_err stays 1 until reset.
- D0 and D1 are fully independent. Pops on both in the same cycle are legal.
- Status flags are combinational decodes of registered occupancy, so they reflect the state after the last edge.
- Occupancy counters are clog2(FIFO_DEPTH)+1 bits wide. Pointers are clog2(FIFO_DEPTH) bits wide.
- idle is combinational: empty_D0 & empty_D1 & ~valid_in.

Decomposition:
- Shared package holds:
  - the word-width constant (6);
  - the DEST_BIT constant;
  - default FIFO_DEPTH and thresholds;
  - destination encoding constants DEST_D0 = 0, DEST_D1 = 1.
- One sub-module, dest_fifo: a single synchronous FIFO with push, pop, registered read data and valid, occupancy-based flags, and an overflow pulse. It is instantiated twice.
- The top level contains only the routing decode, the sticky overflow register and idle.

Test Plan:
- Reset then idle: assert reset 2 cycles, valid_in=0, no pops -> all empty=1, almost_empty=1, valid_out=0, data_out=0, overflow_err=0, idle=1.
- Routing: push 0x05 (bit4=0) then 0x13 (bit4=1), then pop_D0 and pop_D1 in the same cycle -> next cycle data_out_D0=0x05 and data_out_D1=0x13, both valids=1.
- Fill, wrap and order: push 0x01..0x04 to D0 -> almost_full_D0=1 after 3 pushes, full_D0=1 after 4. Then pop 2 and push 0x05, 0x06 -> pops return 0x01..0x06 in order across the pointer wrap.
- Overflow: with D0 full, push 0x0A with no pop -> word dropped, overflow_err=1 and stays 1. Subsequent pops return the original 4 words only.
- Simultaneous push/pop: on D1 full, push+pop -> accepted, full_D1 stays 1, overflow_err=0. On D1 empty, push+pop -> valid_out_D1=0 next cycle, then occupancy=1.
- Mid-operation reset: with D0=2 and D1=3 entries, assert reset for 1 cycle together with a pop -> valid_out=0 and all empty=1 the next cycle. A following pop_D0 gives valid_out_D0=0.

Source files
------------

// File: rtl/dest_demux_fifo_pkg.sv
// Shared constants for the destination demux and its two FIFOs.
package dest_demux_fifo_pkg;
  localparam int BITNUMBER  = 6;
  localparam int DEST_BIT   = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int AF_THRESH  = 3;
  localparam int AE_THRESH  = 1;
  localparam logic DEST_D0  = 1'b0;
  localparam logic DEST_D1  = 1'b1;
endpackage

// File: rtl/dest_demux_fifo_fifo.sv
// Single synchronous FIFO: registered read data/valid, occupancy flags,
// and a one-cycle overflow pulse when a push is dropped.
module dest_fifo
  import dest_demux_fifo_pkg::*;
#(
  parameter int W     = BITNUMBER,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AF    = AF_THRESH,
  parameter int AE    = AE_THRESH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output logic         o_empty,
  output logic         o_full,
  output logic         o_almost_full,
  output logic         o_almost_empty,
  output logic         o_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_data;
  logic          r_valid;

  logic w_do_pop;
  logic w_do_push;

  assign o_empty        = (r_cnt == '0);
  assign o_full         = (r_cnt == CW'(DEPTH));
  assign o_almost_full  = (r_cnt >= CW'(AF));
  assign o_almost_empty = (r_cnt <= CW'(AE));

  // A pop on a full FIFO frees the slot the same-cycle push lands in
  assign w_do_pop   = i_pop & ~o_empty;
  assign w_do_push  = i_push & (~o_full | w_do_pop);
  assign o_overflow = i_push & ~w_do_push;

  assign o_data  = r_data;
  assign o_valid = r_valid;

  always_ff @(posedge clk) begin
    if (w_do_push && !reset) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
      r_data  <= w_do_pop ? r_mem[r_rptr] : '0;
      r_valid <= w_do_pop;
    end
  end
endmodule

// File: rtl/dest_demux_fifo.sv
// Routes each valid mux word by its destination bit into FIFO D0 or D1;
// tracks a sticky overflow and reports idle.
module dest_demux_fifo
  import dest_demux_fifo_pkg::*;
#(
  parameter int BITNUMBER  = dest_demux_fifo_pkg::BITNUMBER,
  parameter int DEST_BIT   = dest_demux_fifo_pkg::DEST_BIT,
  parameter int FIFO_DEPTH = dest_demux_fifo_pkg::FIFO_DEPTH,
  parameter int AF_THRESH  = dest_demux_fifo_pkg::AF_THRESH,
  parameter int AE_THRESH  = dest_demux_fifo_pkg::AE_THRESH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BITNUMBER-1:0] data_in,
  input  logic                 valid_in,
  input  logic                 pop_D0,
  input  logic                 pop_D1,
  output logic [BITNUMBER-1:0] data_out_D0,
  output logic [BITNUMBER-1:0] data_out_D1,
  output logic                 valid_out_D0,
  output logic                 valid_out_D1,
  output logic                 empty_D0,
  output logic                 empty_D1,
  output logic                 full_D0,
  output logic                 full_D1,
  output logic                 almost_full_D0,
  output logic                 almost_full_D1,
  output logic                 almost_empty_D0,
  output logic                 almost_empty_D1,
  output logic                 overflow_err,
  output logic                 idle
);
  logic w_push_d0;
  logic w_push_d1;
  logic w_ovf_d0;
  logic w_ovf_d1;
  logic r_overflow_err;

  assign w_push_d0 = valid_in & (data_in[DEST_BIT] == DEST_D0);
  assign w_push_d1 = valid_in & (data_in[DEST_BIT] == DEST_D1);

  dest_fifo #(
    .W(BITNUMBER), .DEPTH(FIFO_DEPTH),
    .AF(AF_THRESH), .AE(AE_THRESH)
  ) u_d0 (
    .clk(clk), .reset(reset),
    .i_push(w_push_d0), .i_data(data_in), .i_pop(pop_D0),
    .o_data(data_out_D0), .o_valid(valid_out_D0),
    .o_empty(empty_D0), .o_full(full_D0),
    .o_almost_full(almost_full_D0),
    .o_almost_empty(almost_empty_D0),
    .o_overflow(w_ovf_d0)
  );

  dest_fifo #(
    .W(BITNUMBER), .DEPTH(FIFO_DEPTH),
    .AF(AF_THRESH), .AE(AE_THRESH)
  ) u_d1 (
    .clk(clk), .reset(reset),
    .i_push(w_push_d1), .i_data(data_in), .i_pop(pop_D1),
    .o_data(data_out_D1), .o_valid(valid_out_D1),
    .o_empty(empty_D1), .o_full(full_D1),
    .o_almost_full(almost_full_D1),
    .o_almost_empty(almost_empty_D1),
    .o_overflow(w_ovf_d1)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow_err <= 1'b0;
    end else if (w_ovf_d0 || w_ovf_d1) begin
      r_overflow_err <= 1'b1;
    end
  end

  assign overflow_err = r_overflow_err;
  assign idle = empty_D0 & empty_D1 & ~valid_in;
endmodule
